// File: rtl/nanci_defs_pkg.sv
// Shared definitions for the result drain: FSM states and lane-layout defaults.
package nanci_defs;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   localparam int unsigned DEF_ADDR_WIDTH = 2;
   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_WIDTH      = DEF_ADDR_WIDTH + DEF_DATA_WIDTH;
   localparam int unsigned DEF_VALID_BIT  = DEF_WIDTH;

endpackage

// File: rtl/nanci_result_drain_scoreboard.sv
// Address-indexed result buffer with seen mask, lane-priority merge and
// duplicate/conflict detection.
module nanci_scoreboard
   import nanci_defs::*;
#(
   parameter int unsigned N          = 4,
   parameter int unsigned ADDR_WIDTH = 2,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    clear,
   input  logic                                    collect,
   input  logic [N*(ADDR_WIDTH+DATA_WIDTH+1)-1:0]  res_in,
   input  logic [ADDR_WIDTH-1:0]                   rd_addr,
   output logic                                    all_seen,
   output logic                                    dup_hit,
   output logic [DATA_WIDTH-1:0]                   rd_data
);

   localparam int unsigned WIDTH     = ADDR_WIDTH + DATA_WIDTH;
   localparam int unsigned VALID_BIT = WIDTH;
   localparam int unsigned LW        = WIDTH + 1;

   logic [DATA_WIDTH-1:0] buf_q [N];
   logic [DATA_WIDTH-1:0] buf_d [N];
   logic [N-1:0]          seen_q;
   logic [N-1:0]          seen_d;
   logic                  dup_any;
   logic [LW-1:0]         lane;
   logic [ADDR_WIDTH-1:0] lane_addr;
   logic [DATA_WIDTH-1:0] lane_data;

   // Merge lanes in index order; a lane sees the writes of lower lanes from the
   // same cycle, so the lowest lane wins and same-cycle conflicts are flagged.
   always_comb begin
      buf_d     = buf_q;
      seen_d    = seen_q;
      dup_any   = 1'b0;
      lane      = '0;
      lane_addr = '0;
      lane_data = '0;
      for (int unsigned k = 0; k < N; k++) begin
         lane      = res_in[k*LW +: LW];
         lane_addr = lane[WIDTH-1:DATA_WIDTH];
         lane_data = lane[DATA_WIDTH-1:0];
         if (lane[VALID_BIT]) begin
            if (!seen_d[lane_addr]) begin
               buf_d[lane_addr]  = lane_data;
               seen_d[lane_addr] = 1'b1;
            end else if (buf_d[lane_addr] != lane_data) begin
               dup_any = 1'b1;
            end
         end
      end
   end

   // Buffer and seen mask; cleared on reset and on an accepted start.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         seen_q <= '0;
         buf_q  <= '{default: '0};
      end else if (collect) begin
         seen_q <= seen_d;
         buf_q  <= buf_d;
      end
   end

   assign all_seen = &seen_q;
   assign dup_hit  = collect & dup_any;
   assign rd_data  = buf_q[rd_addr];

endmodule

// File: rtl/nanci_result_drain.sv
// Result drain: collects mesh results into an address-ordered buffer and
// streams them out over valid/ready, flagging conflicts and timeouts.
module nanci_result_drain
   import nanci_defs::*;
#(
   parameter int unsigned N          = 4,
   parameter int unsigned ADDR_WIDTH = 2,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    start,
   input  logic [N*(ADDR_WIDTH+DATA_WIDTH+1)-1:0]  res_in,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic [ADDR_WIDTH-1:0]                   out_addr,
   output logic [DATA_WIDTH-1:0]                   out_data,
   output logic                                    out_last,
   output logic                                    busy,
   output logic                                    done,
   output logic                                    err_dup,
   output logic                                    err_timeout
);

   localparam int unsigned TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0]         TIMER_MAX = TW'(TIMEOUT - 1);
   localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(N - 1);

   state_t                state_q, state_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic                  done_q, done_d;
   logic                  err_dup_q, err_dup_d;
   logic                  err_to_q, err_to_d;
   logic                  clear;
   logic                  collect;
   logic                  all_seen;
   logic                  dup_hit;
   logic [DATA_WIDTH-1:0] rd_data;

   assign collect = (state_q == COLLECT);

   nanci_scoreboard #(
      .N          (N),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .collect  (collect),
      .res_in   (res_in),
      .rd_addr  (ptr_q),
      .all_seen (all_seen),
      .dup_hit  (dup_hit),
      .rd_data  (rd_data)
   );

   // Next-state, timer, pointer and flag logic.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      ptr_d     = ptr_q;
      done_d    = 1'b0;
      err_dup_d = err_dup_q;
      err_to_d  = err_to_q;
      clear     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               clear     = 1'b1;
               timer_d   = '0;
               err_dup_d = 1'b0;
               err_to_d  = 1'b0;
               state_d   = COLLECT;
            end
         end
         COLLECT: begin
            if (dup_hit) err_dup_d = 1'b1;
            if (all_seen) begin
               state_d = DRAIN;
               ptr_d   = '0;
            end else if (timer_q == TIMER_MAX) begin
               err_to_d = 1'b1;
               state_d  = DRAIN;
               ptr_d    = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               if (ptr_q == PTR_LAST) begin
                  state_d = IDLE;
                  ptr_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  ptr_d = ptr_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         ptr_q     <= '0;
         done_q    <= 1'b0;
         err_dup_q <= 1'b0;
         err_to_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         ptr_q     <= ptr_d;
         done_q    <= done_d;
         err_dup_q <= err_dup_d;
         err_to_q  <= err_to_d;
      end
   end

   assign out_valid   = (state_q == DRAIN);
   assign out_addr    = ptr_q;
   assign out_data    = out_valid ? rd_data : '0;
   assign out_last    = out_valid && (ptr_q == PTR_LAST);
   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign err_dup     = err_dup_q;
   assign err_timeout = err_to_q;

endmodule

// File: tb/tb_nanci_result_drain.sv
// Self-checking bench for nanci_result_drain against a per-cycle behavioural model.
module tb_nanci_result_drain;

   localparam int N  = 4;
   localparam int AW = 2;
   localparam int DW = 32;
   localparam int TO = 64;
   localparam int LW = AW + DW + 1;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [N*LW-1:0] res_in = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [AW-1:0]   out_addr;
   logic [DW-1:0]   out_data;
   logic            out_last;
   logic            busy;
   logic            done;
   logic            err_dup;
   logic            err_timeout;

   int checks = 0;
   int failures = 0;

   // reference model state
   bit          m_seen [N];
   logic [31:0] m_buf  [N];
   bit          m_dup;
   bit          m_to;
   int          perm   [N];
   logic [31:0] rdata  [N];
   bit          bp_pat [7] = '{1, 0, 0, 1, 0, 1, 1};

   nanci_result_drain #(
      .N          (N),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .TIMEOUT    (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .res_in      (res_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_addr    (out_addr),
      .out_data    (out_data),
      .out_last    (out_last),
      .busy        (busy),
      .done        (done),
      .err_dup     (err_dup),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [LW-1:0] mk_lane(input bit v, input int a, input logic [31:0] d);
      logic [AW-1:0] aa;
      aa = AW'(a);
      return {v, aa, d};
   endfunction

   // Build the lane words for collect cycle c of a scenario and apply the
   // result-capture rules to the model in lane order.
   task automatic drive_lanes(input int mode, input int c);
      logic [LW-1:0] l [N];
      bit            v;
      int            a;
      logic [31:0]   d;
      for (int k = 0; k < N; k++) begin
         case (mode)
            0: l[k] = mk_lane(1, k, 32'(3 - k));
            1: l[k] = mk_lane((k != 2) || (c >= 5), k, 32'h100 + 32'(k));
            2: begin
               if (k == 0)      l[k] = mk_lane(1, 1, 32'hA);
               else if (k == 1) l[k] = (c == 0) ? mk_lane(1, 1, 32'hB) : mk_lane(1, 0, 32'h55);
               else             l[k] = mk_lane(1, k, 32'h20 + 32'(k));
            end
            3: l[k] = mk_lane(k != 3, k, 32'hC0 + 32'(k));
            default: begin
               v = ($urandom_range(0, 3) != 0);
               a = perm[k];
               if ($urandom_range(0, 15) == 0) a = int'($urandom_range(0, N - 1));
               d = rdata[k];
               if ($urandom_range(0, 15) == 0) d = d ^ 32'h1;
               l[k] = mk_lane(v, a, d);
            end
         endcase
      end
      for (int k = 0; k < N; k++) begin
         res_in[k*LW +: LW] = l[k];
         v = l[k][LW-1];
         a = int'(l[k][LW-2:DW]);
         d = l[k][DW-1:0];
         if (v) begin
            if (!m_seen[a]) begin
               m_seen[a] = 1;
               m_buf[a]  = d;
            end else if (m_buf[a] != d) begin
               m_dup = 1;
            end
         end
      end
   endtask

   // One start/collect/drain pass. rmode: 0 always ready, 1 fixed pattern,
   // 2 random. abort_after>0 resets after that many transfers.
   task automatic run(input int mode, input int rmode, input int abort_after, input int exp_cycles);
      int c, words, cyc, tmp, j;
      bit fin, full, rdy;
      for (int k = 0; k < N; k++) begin
         m_seen[k] = 0;
         m_buf[k]  = '0;
         perm[k]   = k;
         rdata[k]  = $urandom;
      end
      m_dup = 0;
      m_to  = 0;
      for (int k = N - 1; k > 0; k--) begin
         j = int'($urandom_range(0, k));
         tmp = perm[k]; perm[k] = perm[j]; perm[j] = tmp;
      end
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", busy, 1);
      c = 0;
      fin = 0;
      while (!fin) begin
         check("collect_no_valid", out_valid, 0);
         full = 1;
         for (int k = 0; k < N; k++) if (!m_seen[k]) full = 0;
         if (full || c == TO - 1) begin
            fin = 1;
            if (!full) m_to = 1;
         end
         drive_lanes(mode, c);
         @(posedge clk); #1;
         c++;
      end
      res_in = '0;
      if (exp_cycles >= 0) check("collect_cycles", 64'(c), 64'(exp_cycles));
      check("drain_entry_valid", out_valid, 1);
      check("err_dup_drain", err_dup, m_dup);
      check("err_timeout_drain", err_timeout, m_to);
      words = 0;
      cyc = 0;
      while (words < N && cyc < 200) begin
         if (abort_after > 0 && words == abort_after) begin
            out_ready = 1'b0;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check("abort_valid", out_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_err_dup", err_dup, 0);
            check("abort_err_timeout", err_timeout, 0);
            check("abort_done", done, 0);
            return;
         end
         if (rmode == 0)      rdy = 1;
         else if (rmode == 1) rdy = bp_pat[cyc % 7];
         else                 rdy = ($urandom_range(0, 1) != 0);
         out_ready = rdy;
         check("out_valid", out_valid, 1);
         check("out_addr", out_addr, 64'(words));
         check("out_data", out_data, m_buf[words]);
         check("out_last", out_last, (words == N - 1));
         check("no_done_in_drain", done, 0);
         if (rdy) words++;
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 1'b0;
      check("transfers", 64'(words), 64'(N));
      check("end_valid", out_valid, 0);
      check("done_pulse", done, 1);
      check("end_busy", busy, 0);
      check("err_dup_end", err_dup, m_dup);
      check("err_timeout_end", err_timeout, m_to);
      @(posedge clk); #1;
      check("done_low", done, 0);
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_last", out_last, 0);
      check("rst_data", out_data, 0);
      check("rst_errs", {err_dup, err_timeout}, 0);
      rst = 1'b0;

      run(0, 0, 0, 2);    // reverse sort
      run(0, 1, 0, 2);    // backpressure
      run(1, 0, 0, 7);    // staggered arrival of addr 2
      run(2, 0, 0, 3);    // conflict on addr 1
      run(3, 2, 0, TO);   // addr 3 never arrives
      run(2, 0, 2, 3);    // reset mid-drain after 2 transfers
      run(0, 0, 0, 2);    // clean pass after reset
      for (int i = 0; i < 20; i++) run(4, 2, 0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nanci_result_drain.md
Name: nanci_result_drain

Overview:
- Reader at the output end of the sorting mesh.
- Captures the {valid, addr, data} result word from each of N processing elements and reassembles them into an address-indexed buffer.
- Streams the buffer out in address order (0..N-1) over a valid/ready interface.
- Flags duplicate or conflicting addresses and incomplete results, for use by the host interface and by mesh-level checkers.

Parameters:
- N, 4, number of PEs / result lanes (power of two).
- ADDR_WIDTH, 2, address field width, equal to log2(N).
- DATA_WIDTH, 32, key/data field width.
- TIMEOUT, 64, maximum cycles spent collecting before giving up (at least 2).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a collection; honoured only in IDLE.
- res_in  in  N*(ADDR_WIDTH+DATA_WIDTH+1)  flattened result lanes. Lane k occupies bits [(k+1)*W-1 : k*W], where W = ADDR_WIDTH+DATA_WIDTH+1. Lane layout, MSB first: valid(1), addr(ADDR_WIDTH), data(DATA_WIDTH).
- out_valid  out  1  output word available.
- out_ready  in  1  consumer accepts the word.
- out_addr  out  ADDR_WIDTH  address of the current word.
- out_data  out  DATA_WIDTH  data of the current word (0 if the address was never received).
- out_last  out  1  current word is address N-1.
- busy  out  1  high in COLLECT or DRAIN.
- done  out  1  one-cycle pulse after the last word is accepted.
- err_dup  out  1  sticky: the same address was seen with differing data.
- err_timeout  out  1  sticky: TIMEOUT expired with addresses missing.

Behaviour:
- Reset: state=IDLE; seen mask, buffer, pointer and timer cleared; every output 0. Reset during COLLECT or DRAIN aborts; out_valid is 0 after that edge.
- States: IDLE, COLLECT, DRAIN.
- IDLE:
  - start=1 clears seen, timer, err_dup and err_timeout, then goes to COLLECT.
  - start in any other state is ignored.
- COLLECT, per cycle, for each lane k with valid=1 at address a:
  - If seen[a]=0: write buf[a]=data and set seen[a].
  - If seen[a]=1 and data equals buf[a]: no action. A PE holding its result steady is benign.
  - If seen[a]=1 and data differs: set err_dup and keep the first value.
  - Two lanes hitting the same unseen address in the same cycle: the lowest lane index wins. err_dup is set if the two data values differ.
  - Lanes with valid=0 are ignored.
- COLLECT exit:
  - The transition is evaluated on the registered seen mask.
  - If seen is all ones, go to DRAIN next cycle with ptr=0.
  - Otherwise, if timer==TIMEOUT-1, set err_timeout and go to DRAIN.
  - Otherwise increment timer. The timer is $clog2(TIMEOUT) bits and never wraps.
- Latency: start sampled at edge t puts the block in COLLECT at t+1. If all lanes are valid with distinct addresses at t+1, seen is full after edge t+1. DRAIN is entered at edge t+2, and out_valid=1 during the cycle after edge t+2.
- DRAIN:
  - out_valid=1, out_addr=ptr, out_data=buf[ptr], out_last=(ptr==N-1), all driven from registers.
  - All out_* signals hold stable while out_valid and !out_ready.
  - On a transfer (out_valid & out_ready), ptr increments.
  - On the last transfer: go to IDLE, pulse done=1 for the next cycle, out_valid=0.
  - The pointer wraps only through that IDLE return.
- err flags persist through DRAIN and IDLE until the next accepted start or reset.
- busy = (state != IDLE).

Decomposition:
- Shared header/package nanci_defs:
  - WIDTH = ADDR_WIDTH+DATA_WIDTH.
  - Lane field index constants: VALID_BIT=WIDTH, address slice, data slice.
  - State encodings IDLE=2'd0, COLLECT=2'd1, DRAIN=2'd2.
- Sub-module nanci_scoreboard: buffer plus seen mask, lane priority merge and dup detection. Outputs all_seen, dup_hit and the read port buf[ptr].
- The top level holds the FSM, timer, pointer and output registers.

Test Plan:
- Reverse sort: lanes k=0..3 hold {1, k, 3-k} from the first COLLECT cycle after start. Stream must be (0,3),(1,2),(2,1),(3,0), with out_last only on addr 3, a done pulse, and both err flags 0.
- Backpressure: same input with out_ready toggling 1,0,0,1,0,1,1. Exactly 4 transfers, out_* stable in every stalled cycle, no word lost or duplicated.
- Staggered arrival: addr 2 arrives 5 cycles after the others. DRAIN starts exactly 1 cycle after the addr-2 write; results are correct.
- Conflict: lanes 0 and 1 both carry addr 1, with data 0xA and 0xB in the same cycle. buf[1]=0xA, err_dup=1, and all addresses complete otherwise.
- Timeout: addr 3 is never valid, TIMEOUT=64. err_timeout rises 64 cycles after entering COLLECT; 4 words are streamed and word 3 has data 0.
- Reset mid-DRAIN after 2 transfers: out_valid=0 the next cycle. A new start then gives a clean 4-word stream with both err flags cleared.
